alu_rr_scheduler: RTL and testbench

- Shares one 4-bit ALU (add, sub, mul, div) between two requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake; results return on a single response channel tagged with the requester ID.
- Sits between the operand sources (pin-mapped or internal masters) and the ALU datapath, and sequences one operation at a time.

---
 rtl/alu_sched_pkg.sv | 18 +
 rtl/alu_core.sv | 60 ++++++
 rtl/alu_rr_scheduler.sv | 137 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: op codes, FSM states, default widths.
package alu_sched_pkg;

    localparam int unsigned DEF_OPW  = 4;
    localparam int unsigned DEF_RESW = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Registered unsigned ALU: loads result and divide-by-zero flag when load is high, holds otherwise.
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int unsigned OPW  = DEF_OPW,
    parameter int unsigned RESW = DEF_RESW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic [1:0]      op,
    output logic [RESW-1:0] result,
    output logic            err
);

    logic [RESW-1:0] result_d, result_q;
    logic            err_d, err_q;
    logic [RESW-1:0] a_ext, b_ext;

    assign a_ext = RESW'(a);
    assign b_ext = RESW'(b);

    always_comb begin
        result_d = result_q;
        err_d    = err_q;
        if (load) begin
            err_d = 1'b0;
            case (op)
                OP_ADD: result_d = a_ext + b_ext;
                OP_SUB: result_d = a_ext - b_ext;
                OP_MUL: result_d = a_ext * b_ext;
                OP_DIV: begin
                    // Divide by zero saturates to all ones and flags the error
                    if (b == '0) begin
                        result_d = '1;
                        err_d    = 1'b1;
                    end else begin
                        result_d = a_ext / b_ext;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered ALU between two valid/ready requesters.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned OPW  = DEF_OPW,
    parameter int unsigned RESW = DEF_RESW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic [1:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    input  logic [1:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_result,
    output logic            rsp_err,
    output logic            busy
);

    state_e         state_d, state_q;
    logic [OPW-1:0] a_d, a_q, b_d, b_q;
    logic [1:0]     op_d, op_q;
    logic           id_d, id_q;
    logic           last_grant_d, last_grant_q;
    logic           rsp_valid_d, rsp_valid_q;
    logic           rsp_id_d, rsp_id_q;
    logic           busy_d, busy_q;
    logic           grant0_c, grant1_c, load_c;

    // On contention the requester that did not win last time gets the grant
    assign grant0_c   = req0_valid & (~req1_valid | last_grant_q);
    assign grant1_c   = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = (state_q == IDLE) & grant0_c;
    assign req1_ready = (state_q == IDLE) & grant1_c;
    assign load_c     = (state_q == EXEC);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    op_d         = req0_op;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                    busy_d       = 1'b1;
                end else if (req1_ready) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    op_d         = req1_op;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                    busy_d       = 1'b1;
                end
            end
            EXEC: begin
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            busy_q       <= busy_d;
        end
    end

    alu_core #(
        .OPW  (OPW),
        .RESW (RESW)
    ) u_alu_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (rsp_result),
        .err    (rsp_err)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a cycle model predicts grants, timing and results.
module tb_alu_rr_scheduler;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, rsp_ready;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_err, busy;
    logic [7:0] rsp_result;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   m_phase = 0;
    logic m_last = 1'b1;

    always #5 clk = ~clk;

    alu_rr_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_a     (a0),
        .req0_b     (b0),
        .req0_op    (op0),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_a     (a1),
        .req1_b     (b1),
        .req1_op    (op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        int unsigned ai = 32'(a);
        int unsigned bi = 32'(b);
        case (op)
            2'b00:   return {1'b0, 8'(ai + bi)};
            2'b01:   return {1'b0, 8'(ai - bi)};
            2'b10:   return {1'b0, 8'(ai * bi)};
            default: return (bi == 0) ? {1'b1, 8'hFF} : {1'b0, 8'(ai / bi)};
        endcase
    endfunction

    // Cycle model: decides what the DUT must show now and what it does at the next edge
    always @(negedge clk) begin
        logic e0, e1;
        logic [8:0] r;
        exp_t x;
        if (rst) begin
            m_phase = 0;
            m_last  = 1'b1;
            sb.delete();
        end else if (m_phase == 0) begin
            e0 = v0 & (~v1 | m_last);
            e1 = v1 & (~v0 | ~m_last);
            chk("ready0_idle", 32'(req0_ready), 32'(e0));
            chk("ready1_idle", 32'(req1_ready), 32'(e1));
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
            chk("busy_idle", 32'(busy), 0);
            if (e0 | e1) begin
                r = e0 ? alu_model(a0, b0, op0) : alu_model(a1, b1, op1);
                x.id  = e1;
                x.res = r[7:0];
                x.err = r[8];
                sb.push_back(x);
                m_last  = e1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            chk("ready0_exec", 32'(req0_ready), 0);
            chk("ready1_exec", 32'(req1_ready), 0);
            chk("rsp_valid_exec", 32'(rsp_valid), 0);
            chk("busy_exec", 32'(busy), 1);
            m_phase = 2;
        end else begin
            chk("ready0_resp", 32'(req0_ready), 0);
            chk("ready1_resp", 32'(req1_ready), 0);
            chk("rsp_valid_resp", 32'(rsp_valid), 1);
            chk("busy_resp", 32'(busy), 1);
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 1);
                m_phase = 0;
            end else begin
                x = sb[0];
                chk("rsp_id", 32'(rsp_id), 32'(x.id));
                chk("rsp_result", 32'(rsp_result), 32'(x.res));
                chk("rsp_err", 32'(rsp_err), 32'(x.err));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    m_phase = 0;
                end
            end
        end
    end

    task automatic send(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op);
        bit done = 0;
        if (id == 0) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        else         begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!rst && ((id == 0) ? req0_ready : req1_ready)) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id == 0) v0 = 1'b0;
        else         v1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (m_phase == 0 && sb.size() == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic contention(input int n);
        fork
            for (int i = 0; i < n; i++) send(0, 4'd15, 4'd15, 2'b10);
            for (int i = 0; i < n; i++) send(1, 4'd3, 4'd5, 2'b01);
        join
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");
        chk("ready0_after_reset", 32'(req0_ready), 0);
        chk("ready1_after_reset", 32'(req1_ready), 0);

        send(0, 4'd9, 4'd7, 2'b00);
        wait_idle();

        pulse_rst(1);
        contention(2);

        send(1, 4'd12, 4'd0, 2'b11);
        send(1, 4'd13, 4'd4, 2'b11);
        wait_idle();

        // Backpressure with a second request waiting behind the stalled response
        rsp_ready = 1'b0;
        fork
            send(0, 4'd6, 4'd2, 2'b10);
            send(1, 4'd2, 4'd9, 2'b01);
            begin
                wait (m_phase == 2);
                @(posedge clk);
                repeat (5) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset while in EXEC
        fork
            send(0, 4'd7, 4'd7, 2'b10);
            begin
                wait (m_phase == 1);
                @(posedge clk);
                #1;
                pulse_rst(1);
            end
        join
        chk_reset_outputs("rst_exec");

        // Reset while in RESP with the consumer stalled
        rsp_ready = 1'b0;
        fork
            send(1, 4'd8, 4'd3, 2'b00);
            begin
                wait (m_phase == 2);
                @(posedge clk);
                #1;
                pulse_rst(1);
            end
        join
        rsp_ready = 1'b1;
        chk_reset_outputs("rst_resp");
        contention(2);

        for (int i = 0; i < 16; i++) begin
            fork
                send(0, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
                send(1, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
            join
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
